// File: rtl/msk_and_hpc2_pipe_if.sv
// Handshake and share bus between share registers, the HPC2 AND gadget and its consumer.
// The producer/consumer side uses the master view and the gadget uses the slave view.
interface msk_and_hpc2_pipe_if #(
    parameter int d = 2,
    parameter int W = 1
);
    localparam int R = W * d * (d - 1) / 2;

    logic             in_valid;
    logic             rnd_valid;
    logic             in_ready;
    logic [d*W-1:0]   ina;
    logic [d*W-1:0]   inb;
    logic [d*W-1:0]   inc;
    logic [R-1:0]     rnd;
    logic             out_valid;
    logic             out_ready;
    logic [d*W-1:0]   out;

    modport master (
        output in_valid, rnd_valid, ina, inb, inc, rnd, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, rnd_valid, ina, inb, inc, rnd, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/msk_and_hpc2_pipe.sv
// d-share, W-slice HPC2 masked AND (MODE=0) or AND-XOR (MODE=1) gadget.
// Two register stages with valid/ready handshake; a stalled consumer freezes the whole pipe.
module msk_and_hpc2_pipe #(
    parameter int d    = 2,
    parameter int W    = 1,
    parameter int MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    msk_and_hpc2_pipe_if.slave bus
);
    localparam int NP = d * (d - 1);
    localparam int NU = NP / 2;

    // Unordered pair (i,j) to its slot in the rnd bus; r_ij and r_ji are the same bits.
    function automatic int pairIdx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
    endfunction

    function automatic int ordIdx(input int i, input int j);
        return i * (d - 1) + ((j < i) ? j : j - 1);
    endfunction

    logic           w_stall;
    logic           w_accept;
    logic [d*W-1:0] w_c;
    logic [d*W-1:0] w_out;

    logic           r_s1Valid;
    logic           r_s2Valid;
    logic [W-1:0]   r_a   [d];
    logic [W-1:0]   r_b   [d];
    logic [W-1:0]   r_c   [d];
    logic [W-1:0]   r_rnd [NU];
    logic [W-1:0]   r_v   [NP];
    logic [W-1:0]   r_t   [d];
    logic [W-1:0]   r_u   [NP];
    logic [W-1:0]   r_w   [NP];

    assign w_stall       = r_s2Valid & ~bus.out_ready;
    assign w_accept      = bus.in_valid & bus.rnd_valid & ~w_stall;
    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_s2Valid;
    assign bus.out       = w_out;

    generate
        if (MODE == 1) begin : g_withC
            assign w_c = bus.inc;
        end else begin : g_noC
            assign w_c = '0;
        end
    endgenerate

    // Only share j meets r_ij before the first flop, so no path mixes two shares combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            for (int i = 0; i < d; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_c[i] <= '0;
            end
            for (int p = 0; p < NU; p++) r_rnd[p] <= '0;
            for (int q = 0; q < NP; q++) r_v[q] <= '0;
        end else if (!w_stall) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < d; i++) begin
                    r_a[i] <= bus.ina[i*W +: W];
                    r_b[i] <= bus.inb[i*W +: W];
                    r_c[i] <= w_c[i*W +: W];
                    for (int j = 0; j < d; j++) begin
                        if (j != i)
                            r_v[ordIdx(i, j)] <= bus.inb[j*W +: W] ^ bus.rnd[pairIdx(i, j)*W +: W];
                    end
                end
                for (int p = 0; p < NU; p++) r_rnd[p] <= bus.rnd[p*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            for (int i = 0; i < d; i++) r_t[i] <= '0;
            for (int q = 0; q < NP; q++) begin
                r_u[q] <= '0;
                r_w[q] <= '0;
            end
        end else if (!w_stall) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                for (int i = 0; i < d; i++) begin
                    r_t[i] <= (r_a[i] & r_b[i]) ^ r_c[i];
                    for (int j = 0; j < d; j++) begin
                        if (j != i) begin
                            r_u[ordIdx(i, j)] <= ~r_a[i] & r_rnd[pairIdx(i, j)];
                            r_w[ordIdx(i, j)] <= r_a[i] & r_v[ordIdx(i, j)];
                        end
                    end
                end
            end
        end
    end

    // Each u/w term comes straight from its own flop; compression happens only here.
    always_comb begin
        w_out = '0;
        for (int i = 0; i < d; i++) begin
            w_out[i*W +: W] = r_t[i];
            for (int j = 0; j < d; j++) begin
                if (j != i)
                    w_out[i*W +: W] = w_out[i*W +: W] ^ r_u[ordIdx(i, j)] ^ r_w[ordIdx(i, j)];
            end
        end
    end
endmodule

// File: tb/tb_msk_and_hpc2_pipe.sv
// Bench for msk_and_hpc2_pipe: fixed vectors on d=2/W=4 (both modes) and a
// scoreboarded random stream on d=3/W=8 AND-XOR with stalls, bubbles and reset.
module tb_msk_and_hpc2_pipe;
    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    msk_and_hpc2_pipe_if #(.d(2), .W(4)) ifA ();
    msk_and_hpc2_pipe_if #(.d(2), .W(4)) ifB ();
    msk_and_hpc2_pipe_if #(.d(3), .W(8)) ifC ();

    msk_and_hpc2_pipe #(.d(2), .W(4), .MODE(0)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    msk_and_hpc2_pipe #(.d(2), .W(4), .MODE(1)) dutB (.clk(clk), .rst(rst), .bus(ifB));
    msk_and_hpc2_pipe #(.d(3), .W(8), .MODE(1)) dutC (.clk(clk), .rst(rst), .bus(ifC));

    assign ifB.in_valid  = ifA.in_valid;
    assign ifB.rnd_valid = ifA.rnd_valid;
    assign ifB.ina       = ifA.ina;
    assign ifB.inb       = ifA.inb;
    assign ifB.inc       = ifA.inc;
    assign ifB.rnd       = ifA.rnd;
    assign ifB.out_ready = ifA.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a0, a1, b0, b1, c0, c1, r;
        logic [3:0] expAnd;
        logic [3:0] expAndXor;
    } vec_t;

    vec_t vecs [6];

    logic [7:0] expQ [$];
    logic       bigAccept = 1'b0;
    logic       stallHeld = 1'b0;
    logic [23:0] heldOut;
    int         acceptCount = 0;
    int         outCount = 0;
    int         notReadyCycles = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] unmask3(input logic [23:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16];
    endfunction

    // Reference: unmasked (a&b)^c from the XOR of every sharing.
    function automatic logic [7:0] refAndXor(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        return (unmask3(a) & unmask3(b)) ^ unmask3(c);
    endfunction

    task automatic newBeat();
        ifC.ina = {$urandom} % (1 << 24);
        ifC.inb = {$urandom} % (1 << 24);
        ifC.inc = {$urandom} % (1 << 24);
        ifC.rnd = {$urandom} % (1 << 24);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            stallHeld = 1'b0;
            bigAccept = 1'b0;
        end else begin
            bigAccept = ifC.in_valid & ifC.rnd_valid & ifC.in_ready;
            checkOutput("c_inReady", ifC.in_ready, !(ifC.out_valid && !ifC.out_ready));
            if (!ifC.in_ready) notReadyCycles++;
            if (stallHeld) begin
                checkOutput("c_holdValid", ifC.out_valid, 1);
                checkOutput("c_holdData", ifC.out, heldOut);
            end
            stallHeld = ifC.out_valid & ~ifC.out_ready;
            heldOut   = ifC.out;
            if (ifC.out_valid && ifC.out_ready) begin
                outCount++;
                if (expQ.size() == 0) checkOutput("c_spurious", 1, 0);
                else checkOutput("c_result", unmask3(ifC.out), expQ.pop_front());
            end
            if (bigAccept) begin
                expQ.push_back(refAndXor(ifC.ina, ifC.inb, ifC.inc));
                acceptCount++;
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        ifA.ina       = {v.a1, v.a0};
        ifA.inb       = {v.b1, v.b0};
        ifA.inc       = {v.c1, v.c0};
        ifA.rnd       = v.r;
        ifA.in_valid  = 1'b1;
        ifA.rnd_valid = 1'b1;
        @(posedge clk); #1;
        ifA.in_valid  = 1'b0;
        ifA.rnd_valid = 1'b0;
        @(negedge clk);
        checkOutput("s_latencyEarly", ifA.out_valid, 0);
        @(negedge clk);
        checkOutput("s_validA", ifA.out_valid, 1);
        checkOutput("s_validB", ifB.out_valid, 1);
        checkOutput("s_andA", ifA.out[3:0] ^ ifA.out[7:4], v.expAnd);
        checkOutput("s_andXorB", ifB.out[3:0] ^ ifB.out[7:4], v.expAndXor);
    endtask

    task automatic runStream(input int nBeats, input bit randomCtl, input bit stallWindow);
        int sent = 0;
        int cyc = 0;
        newBeat();
        while (sent < nBeats && cyc < 20000) begin
            ifC.in_valid  = randomCtl ? ($urandom_range(0, 3) != 0) : 1'b1;
            ifC.rnd_valid = randomCtl ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stallWindow) ifC.out_ready = !(cyc >= 3 && cyc <= 5);
            else ifC.out_ready = randomCtl ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk); #1;
            if (bigAccept) begin
                sent++;
                newBeat();
            end
            cyc++;
        end
        ifC.in_valid  = 1'b0;
        ifC.out_ready = 1'b1;
        for (int k = 0; k < 50 && expQ.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput("c_sent", sent, nBeats);
        checkOutput("c_drained", expQ.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] savedShares;
        int acc0;
        int out0;

        vecs[0] = '{4'h3, 4'h9, 4'h5, 4'h9, 4'h1, 4'h4, 4'h6, 4'h8, 4'hD};
        vecs[1] = '{4'h3, 4'h9, 4'h5, 4'h9, 4'h1, 4'h4, 4'h0, 4'h8, 4'hD};
        vecs[2] = '{4'h3, 4'h9, 4'h5, 4'h9, 4'h1, 4'h4, 4'hF, 4'h8, 4'hD};
        vecs[3] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hA, 4'hF, 4'hF};
        vecs[4] = '{4'h5, 4'h5, 4'h7, 4'h3, 4'h2, 4'h8, 4'h3, 4'h0, 4'hA};
        vecs[5] = '{4'hC, 4'h6, 4'h1, 4'hE, 4'hF, 4'hF, 4'h9, 4'hA, 4'hA};

        rst = 1'b1;
        ifA.in_valid = 1'b0; ifA.rnd_valid = 1'b0; ifA.out_ready = 1'b1;
        ifA.ina = '0; ifA.inb = '0; ifA.inc = '0; ifA.rnd = '0;
        ifC.in_valid = 1'b0; ifC.rnd_valid = 1'b0; ifC.out_ready = 1'b1;
        ifC.ina = '0; ifC.inb = '0; ifC.inc = '0; ifC.rnd = '0;
        savedShares = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("r_outValidA", ifA.out_valid, 0);
        checkOutput("r_outA", ifA.out, 0);
        checkOutput("r_inReadyA", ifA.in_ready, 1);
        checkOutput("r_outValidC", ifC.out_valid, 0);
        checkOutput("r_outC", ifC.out, 0);
        checkOutput("r_inReadyC", ifC.in_ready, 1);

        for (int n = 0; n < 6; n++) begin
            applyStimulus(vecs[n]);
            if (n == 0) begin
                checkOutput("s_sharesA", ifA.out, 8'hE6);
                checkOutput("s_sharesB", ifB.out, 8'hA7);
            end
            if (n == 1) savedShares = ifB.out;
            if (n == 2) checkOutput("s_sharesDiffer", savedShares != ifB.out, 1);
            @(posedge clk); #1;
            checkOutput("s_drained", ifA.out_valid, 0);
        end

        notReadyCycles = 0;
        out0 = outCount;
        runStream(16, 1'b0, 1'b1);
        checkOutput("c_stallCycles", notReadyCycles, 3);
        checkOutput("c_streamOuts", outCount - out0, 16);

        // rnd_valid toggling 1,0,1 under a steady in_valid
        acc0 = acceptCount;
        newBeat();
        ifC.in_valid = 1'b1; ifC.rnd_valid = 1'b1;
        @(posedge clk); #1;
        newBeat();
        ifC.rnd_valid = 1'b0;
        @(posedge clk); #1;
        ifC.rnd_valid = 1'b1;
        @(negedge clk);
        checkOutput("t_valid1", ifC.out_valid, 1);
        @(posedge clk); #1;
        ifC.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("t_bubble", ifC.out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t_valid2", ifC.out_valid, 1);
        checkOutput("t_accepts", acceptCount - acc0, 2);
        repeat (3) @(posedge clk);
        #1;

        // Reset with two beats in flight
        newBeat();
        ifC.in_valid = 1'b1; ifC.rnd_valid = 1'b1;
        @(posedge clk); #1;
        newBeat();
        @(posedge clk); #1;
        ifC.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("x_outValid", ifC.out_valid, 0);
        checkOutput("x_out", ifC.out, 0);
        checkOutput("x_inReady", ifC.in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("x_noStale", ifC.out_valid, 0);
        end
        @(posedge clk); #1;

        out0 = outCount;
        runStream(1000, 1'b1, 1'b0);
        checkOutput("c_randomOuts", outCount - out0, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
